// File: rtl/regmask_pkg.sv
// Shared constants and state encoding for the register-mask to address encoder.
package regmask_pkg;

  localparam int unsigned N_REGS = 32;
  localparam int unsigned AW     = $clog2(N_REGS);
  localparam int unsigned CW     = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/regmask_encoder_if.sv
// Mask-in / address-out handshake bundle between a mask producer/consumer and regmask_encoder.
interface regmask_encoder_if;
  import regmask_pkg::*;

  logic              mask_valid;
  logic [N_REGS-1:0] mask_in;
  logic              mask_ready;
  logic              addr_valid;
  logic [AW-1:0]     addr_out;
  logic              addr_ready;
  logic              done;
  logic [CW-1:0]     emit_cnt;

  modport master (
    output mask_valid, mask_in, addr_ready,
    input  mask_ready, addr_valid, addr_out, done, emit_cnt
  );

  modport slave (
    input  mask_valid, mask_in, addr_ready,
    output mask_ready, addr_valid, addr_out, done, emit_cnt
  );

endinterface

// File: rtl/regmask_encoder_prio_enc32.sv
// Combinational lowest-set-bit priority encoder over a 32-bit vector.
module prio_enc32
  import regmask_pkg::*;
(
  input  logic [N_REGS-1:0] in,
  output logic [AW-1:0]     idx,
  output logic              any
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int unsigned i = N_REGS; i > 0; i--) begin
      if (in[i-1]) idx = AW'(i - 1);
    end
  end

  assign any = |in;

endmodule

// File: rtl/regmask_encoder.sv
// Converts a register bitmask into one 5-bit address per handshake, lowest first, then pulses done.
// Optional macro REGMASK_SKIP_R0_EN drops bit 0 at capture so register $zero is never emitted.
module regmask_encoder
  import regmask_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regmask_encoder_if.slave  bus
);

  state_t            state;
  logic [N_REGS-1:0] pending;
  logic [N_REGS-1:0] captured;
  logic [N_REGS-1:0] pending_next;
  logic [AW-1:0]     idx;
  logic              any;

`ifdef REGMASK_SKIP_R0_EN
  assign captured = {bus.mask_in[N_REGS-1:1], 1'b0};
`else
  assign captured = bus.mask_in;
`endif

  prio_enc32 u_prio (
    .in  (pending),
    .idx (idx),
    .any (any)
  );

  assign bus.addr_out = idx;

  // x & (x-1) clears exactly the lowest set bit, which is the one on addr_out.
  assign pending_next = pending & (pending - N_REGS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      pending        <= '0;
      bus.mask_ready <= 1'b1;
      bus.addr_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.emit_cnt   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.mask_valid) begin
            pending      <= captured;
            bus.emit_cnt <= '0;
            if (captured == '0) begin
              bus.done <= 1'b1;
            end else begin
              state          <= ST_SCAN;
              bus.mask_ready <= 1'b0;
              bus.addr_valid <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (bus.addr_ready && any) begin
            pending      <= pending_next;
            bus.emit_cnt <= bus.emit_cnt + CW'(1);
            if (pending_next == '0) begin
              state          <= ST_IDLE;
              bus.mask_ready <= 1'b1;
              bus.addr_valid <= 1'b0;
              bus.done       <= 1'b1;
            end
          end
        end
        default: begin
          state          <= ST_IDLE;
          pending        <= '0;
          bus.mask_ready <= 1'b1;
          bus.addr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regmask_encoder.sv
// Scoreboard bench for regmask_encoder: expected addresses queued at mask offer, checked as they drain.
module tb_regmask_encoder;
  import regmask_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt;
  logic [AW-1:0] exp_q[$];

  regmask_encoder_if bus ();

  regmask_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one mask for a single cycle and queues the addresses it should produce.
  task automatic offer(input logic [31:0] m);
    logic [31:0] mm;
    mm = m;
`ifdef REGMASK_SKIP_R0_EN
    mm[0] = 1'b0;
`endif
    exp_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (mm[i]) begin
        exp_q.push_back(AW'(i));
        exp_cnt++;
      end
    end
    bus.mask_valid = 1'b1;
    bus.mask_in    = m;
    tick();
    bus.mask_valid = 1'b0;
    bus.mask_in    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.mask_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.emit_cnt !== 6'd0 || bus.addr_out !== 5'd0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b done=%b cnt=%0d addr=%0d, required 1 0 0 0 0",
               bus.mask_ready, bus.addr_valid, bus.done, bus.emit_cnt, bus.addr_out);
    end
  endtask

  task automatic test_empty_mask();
    offer(32'h0000_0000);
    checks++;
    if (bus.done !== 1'b1 || bus.addr_valid !== 1'b0 || bus.emit_cnt !== 6'd0 || bus.mask_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: done=%b valid=%b cnt=%0d ready=%b, required 1 0 0 1",
               bus.done, bus.addr_valid, bus.emit_cnt, bus.mask_ready);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_pulse: done=%b valid=%b, required 0 0", bus.done, bus.addr_valid);
    end
  endtask

  task automatic test_mixed();
    int cyc = 0;
    bus.addr_ready = 1'b1;
    offer(32'h8000_0013);
    while (!bus.done && cyc < 40) begin
      if (bus.addr_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.addr_out !== exp_q[0]) begin
          errors++;
          $display("FAIL mixed_addr: got %0d, required %0d", bus.addr_out, exp_q.size() ? exp_q[0] : 5'dx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || cyc != exp_cnt || bus.emit_cnt !== 6'(exp_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mixed_done: done=%b cycles=%0d cnt=%0d left=%0d, required 1 %0d %0d 0",
               bus.done, cyc, bus.emit_cnt, exp_q.size(), exp_cnt, exp_cnt);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_stall();
    int cyc = 0;
    bus.addr_ready = 1'b0;
    offer(32'h0000_0420);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (bus.addr_valid !== 1'b1 || bus.addr_out !== 5'd5 || bus.emit_cnt !== 6'd0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b addr=%0d cnt=%0d, required 1 5 0",
                 bus.addr_valid, bus.addr_out, bus.emit_cnt);
      end
      tick();
    end
    bus.addr_ready = 1'b1;
    while (!bus.done && cyc < 10) begin
      if (bus.addr_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.addr_out !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_addr: got %0d, required %0d", bus.addr_out, exp_q.size() ? exp_q[0] : 5'dx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done: done=%b cnt=%0d left=%0d, required 1 2 0", bus.done, bus.emit_cnt, exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    bus.addr_ready = 1'b1;
    offer(32'hFFFF_FFFF);
    while (!bus.done && cyc < 40) begin
      if (bus.addr_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.addr_out !== exp_q[0]) begin
          errors++;
          $display("FAIL ones_addr: got %0d, required %0d", bus.addr_out, exp_q.size() ? exp_q[0] : 5'dx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || cyc != exp_cnt || bus.emit_cnt !== 6'(exp_cnt) || bus.mask_ready !== 1'b1) begin
      errors++;
      $display("FAIL ones_done: done=%b cycles=%0d cnt=%0d ready=%b, required 1 %0d %0d 1",
               bus.done, cyc, bus.emit_cnt, bus.mask_ready, exp_cnt, exp_cnt);
    end
    exp_q.delete();
    offer(32'h0000_0002);
    checks++;
    if (bus.addr_valid !== 1'b1 || bus.addr_out !== 5'd1 || bus.emit_cnt !== 6'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: valid=%b addr=%0d cnt=%0d done=%b, required 1 1 0 0",
               bus.addr_valid, bus.addr_out, bus.emit_cnt, bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd1) begin
      errors++;
      $display("FAIL b2b_done: done=%b cnt=%0d, required 1 1", bus.done, bus.emit_cnt);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset_mid_scan();
    int cyc = 0;
    bus.addr_ready = 1'b1;
    offer(32'h0000_00F0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.addr_valid !== 1'b1 || bus.addr_out !== exp_q[0]) begin
        errors++;
        $display("FAIL rst_pre_addr: valid=%b addr=%0d, required 1 %0d", bus.addr_valid, bus.addr_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.mask_ready !== 1'b1 || bus.addr_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.emit_cnt !== 6'd0 || bus.addr_out !== 5'd0) begin
      errors++;
      $display("FAIL rst_abort: ready=%b valid=%b done=%b cnt=%0d addr=%0d, required 1 0 0 0 0",
               bus.mask_ready, bus.addr_valid, bus.done, bus.emit_cnt, bus.addr_out);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: done=%b valid=%b, required 0 0", bus.done, bus.addr_valid);
    end
    offer(32'h0000_0002);
    while (!bus.done && cyc < 10) begin
      if (bus.addr_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.addr_out !== exp_q[0]) begin
          errors++;
          $display("FAIL rst_next_addr: got %0d, required %0d", bus.addr_out, exp_q.size() ? exp_q[0] : 5'dx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_next_done: done=%b cnt=%0d left=%0d, required 1 1 0", bus.done, bus.emit_cnt, exp_q.size());
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_ignore_mask();
    int cyc = 0;
    bus.addr_ready = 1'b1;
    offer(32'h0000_0006);
    bus.mask_valid = 1'b1;
    bus.mask_in    = 32'h0000_0001;
    checks++;
    if (bus.mask_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignore_ready: got %b, required 0", bus.mask_ready);
    end
    while (!bus.done && cyc < 10) begin
      if (bus.addr_valid) begin
        checks++;
        if (exp_q.size() == 0 || bus.addr_out !== exp_q[0]) begin
          errors++;
          $display("FAIL ignore_addr: got %0d, required %0d", bus.addr_out, exp_q.size() ? exp_q[0] : 5'dx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      bus.mask_valid = 1'b0;
      bus.mask_in    = '0;
      cyc++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_done: done=%b cnt=%0d left=%0d, required 1 2 0", bus.done, bus.emit_cnt, exp_q.size());
    end
    tick();
    tick();
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: valid=%b done=%b, required 0 0", bus.addr_valid, bus.done);
    end
    exp_q.delete();
  endtask

  initial begin
    bus.mask_valid = 1'b0;
    bus.mask_in    = '0;
    bus.addr_ready = 1'b0;
    test_reset();
    test_empty_mask();
    test_mixed();
    test_stall();
    test_back_to_back();
    test_reset_mid_scan();
    test_ignore_mask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
